// File: rtl/text_cursor_sequencer_pkg.sv
// Shared screen geometry, ASCII control codes and state types for the text cursor sequencer.
package typer_pkg;

   localparam int SCREEN_WIDTH  = 640;
   localparam int SCREEN_HEIGHT = 480;
   localparam int CHAR_WIDTH    = 20;
   localparam int CHAR_HEIGHT   = 30;
   localparam int FIFO_DEPTH    = 8;

   localparam int COLS       = SCREEN_WIDTH / CHAR_WIDTH;
   localparam int ROWS       = SCREEN_HEIGHT / CHAR_HEIGHT;
   localparam int ROW_STRIDE = SCREEN_WIDTH * CHAR_HEIGHT;

   localparam logic [7:0] ASCII_LF    = 8'h0A;
   localparam logic [7:0] ASCII_BS    = 8'h08;
   localparam logic [7:0] ASCII_SPACE = 8'h20;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ADVANCE} seq_state_t;

   // What the ADVANCE state does to the cursor for the character just handled.
   typedef enum logic [1:0] {ADV_STEP, ADV_NEWLINE, ADV_HOLD} advance_kind_t;

endpackage

// File: rtl/text_cursor_sequencer_if.sv
// Character input and glyph-draw handshake bundle; master is the sequencer side.
interface text_cursor_sequencer_if;

   logic [7:0]  char_in;
   logic        char_valid;
   logic        char_ready;
   logic        finished_saving_char;
   logic        start_writing_character;
   logic [7:0]  character_output;
   logic [18:0] top_left_corner_address;

   modport master (
      input  char_in, char_valid, finished_saving_char,
      output char_ready, start_writing_character, character_output, top_left_corner_address
   );

   modport slave (
      output char_in, char_valid, finished_saving_char,
      input  char_ready, start_writing_character, character_output, top_left_corner_address
   );

endinterface

// File: rtl/text_cursor_sequencer_char_fifo.sv
// Synchronous first-word-fall-through FIFO buffering incoming character codes.
module char_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic [WIDTH-1:0]        push_data,
   input  logic                    push,
   input  logic                    pop,
   output logic [WIDTH-1:0]        head,
   output logic                    full,
   output logic                    empty,
   output logic [$clog2(DEPTH):0]  count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == (AW + 1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem[rd_ptr];

   always_ff @(posedge clock) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

   // A push refused while full is simply dropped; the source is expected to hold it.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + (AW + 1)'(1);
            2'b01:   count <= count - (AW + 1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/text_cursor_sequencer.sv
// Feeds characters one at a time to the glyph drawer while tracking a 32x16 text cursor.
// Optional backspace handling is enabled by defining TYPER_BACKSPACE_EN.
module text_cursor_sequencer
   import typer_pkg::*;
(
   input  logic                    clock,
   input  logic                    reset,
   text_cursor_sequencer_if.master bus,
   output logic [4:0]              cursor_col,
   output logic [3:0]              cursor_row,
   output logic [3:0]              fifo_count,
   output logic                    seq_busy
);

   localparam logic [4:0]  LAST_COL = 5'(COLS - 1);
   localparam logic [3:0]  LAST_ROW = 4'(ROWS - 1);
   localparam logic [9:0]  COL_STEP = 10'(CHAR_WIDTH);
   localparam logic [18:0] ROW_STEP = 19'(ROW_STRIDE);

   seq_state_t    state;
   seq_state_t    state_next;
   advance_kind_t kind;

   logic [7:0]  head;
   logic        fifo_full;
   logic        fifo_empty;
   logic        pop;
   logic        load_draw;
   logic        load_newline;
   logic [18:0] row_base;
   logic [9:0]  col_offset;
   logic [18:0] cell_addr;
   logic [7:0]  char_latch;
   logic [18:0] addr_latch;
   logic        line_break;

   char_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clock     (clock),
      .reset     (reset),
      .push_data (bus.char_in),
      .push      (bus.char_valid),
      .pop       (pop),
      .head      (head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   assign cell_addr  = row_base + {9'd0, col_offset};
   assign line_break = (kind == ADV_NEWLINE) || (cursor_col == LAST_COL);

   assign bus.char_ready              = !fifo_full;
   assign bus.start_writing_character = (state == ISSUE);
   assign bus.character_output        = char_latch;
   assign bus.top_left_corner_address = addr_latch;
   assign seq_busy                    = (state != IDLE);

`ifdef TYPER_BACKSPACE_EN
   localparam logic [9:0] LAST_COL_OFFSET = 10'(CHAR_WIDTH * (COLS - 1));

   logic        load_backspace;
   logic [4:0]  back_col;
   logic [3:0]  back_row;
   logic [18:0] back_row_base;
   logic [9:0]  back_col_offset;

   // The cell one step behind the cursor; the top-left cell steps back onto itself.
   always_comb begin
      back_col        = cursor_col;
      back_row        = cursor_row;
      back_row_base   = row_base;
      back_col_offset = col_offset;
      if (cursor_col != '0) begin
         back_col        = cursor_col - 5'd1;
         back_col_offset = col_offset - COL_STEP;
      end else if (cursor_row != '0) begin
         back_col        = LAST_COL;
         back_col_offset = LAST_COL_OFFSET;
         back_row        = cursor_row - 4'd1;
         back_row_base   = row_base - ROW_STEP;
      end
   end
`endif

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   // Only pull a character while the drawer reports idle, so ISSUE always starts a fresh handshake.
   always_comb begin
      state_next   = state;
      pop          = 1'b0;
      load_draw    = 1'b0;
      load_newline = 1'b0;
`ifdef TYPER_BACKSPACE_EN
      load_backspace = 1'b0;
`endif
      case (state)
         IDLE: begin
            if (!fifo_empty && bus.finished_saving_char) begin
               pop = 1'b1;
               if (head == ASCII_LF) begin
                  load_newline = 1'b1;
                  state_next   = ADVANCE;
               end
`ifdef TYPER_BACKSPACE_EN
               else if (head == ASCII_BS) begin
                  load_backspace = 1'b1;
                  state_next     = ISSUE;
               end
`endif
               else begin
                  load_draw  = 1'b1;
                  state_next = ISSUE;
               end
            end
         end
         ISSUE:   if (!bus.finished_saving_char) state_next = WAIT;
         WAIT:    if (bus.finished_saving_char) state_next = ADVANCE;
         ADVANCE: state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Cursor position, row base and column offset move together so the address never needs a multiply.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cursor_col <= '0;
         cursor_row <= '0;
         row_base   <= '0;
         col_offset <= '0;
         char_latch <= '0;
         addr_latch <= '0;
         kind       <= ADV_STEP;
      end else begin
         if (load_draw) begin
            char_latch <= head;
            addr_latch <= cell_addr;
            kind       <= ADV_STEP;
         end
         if (load_newline) kind <= ADV_NEWLINE;
`ifdef TYPER_BACKSPACE_EN
         if (load_backspace) begin
            char_latch <= ASCII_SPACE;
            addr_latch <= back_row_base + {9'd0, back_col_offset};
            cursor_col <= back_col;
            cursor_row <= back_row;
            row_base   <= back_row_base;
            col_offset <= back_col_offset;
            kind       <= ADV_HOLD;
         end
`endif
         if (state == ADVANCE && kind != ADV_HOLD) begin
            if (line_break) begin
               cursor_col <= '0;
               col_offset <= '0;
               if (cursor_row == LAST_ROW) begin
                  cursor_row <= '0;
                  row_base   <= '0;
               end else begin
                  cursor_row <= cursor_row + 4'd1;
                  row_base   <= row_base + ROW_STEP;
               end
            end else begin
               cursor_col <= cursor_col + 5'd1;
               col_offset <= col_offset + COL_STEP;
            end
         end
      end
   end

endmodule

// File: tb/tb_text_cursor_sequencer.sv
// Directed bench for text_cursor_sequencer with a behavioural glyph-drawer model.
module tb_text_cursor_sequencer;
   import typer_pkg::*;

   typedef struct {
      logic [7:0]  code;
      logic        drawn;
      logic [7:0]  exp_char;
      logic [18:0] exp_addr;
      logic [4:0]  exp_col;
      logic [3:0]  exp_row;
   } vec_t;

   logic       clock = 1'b0;
   logic       reset;
   logic       drawer_busy;
   logic       hold_busy;
   logic [4:0] cursor_col;
   logic [3:0] cursor_row;
   logic [3:0] fifo_count;
   logic       seq_busy;

   int compared   = 0;
   int mismatched = 0;

   logic [7:0]  drawn_char[$];
   logic [18:0] drawn_addr[$];
   vec_t        vectors[13];

   text_cursor_sequencer_if bus();

   assign bus.finished_saving_char = !(drawer_busy || hold_busy);

   always #5 clock = ~clock;

   text_cursor_sequencer dut (
      .clock      (clock),
      .reset      (reset),
      .bus        (bus.master),
      .cursor_col (cursor_col),
      .cursor_row (cursor_row),
      .fifo_count (fifo_count),
      .seq_busy   (seq_busy)
   );

   // Drawing stage: accepts a request, stays busy two cycles, records what it drew.
   initial begin
      drawer_busy = 1'b0;
      forever begin
         @(negedge clock);
         if (bus.start_writing_character && !drawer_busy) begin
            drawn_char.push_back(bus.character_output);
            drawn_addr.push_back(bus.top_left_corner_address);
            drawer_busy = 1'b1;
            repeat (2) @(negedge clock);
            drawer_busy = 1'b0;
         end
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, actual, actual, expected, expected);
      end
   endtask

   task automatic apply_stimulus(input logic [7:0] code);
      int guard = 0;
      @(negedge clock);
      bus.char_in    = code;
      bus.char_valid = 1'b1;
      while (!bus.char_ready && guard < 2000) begin
         @(negedge clock);
         guard++;
      end
      check_output("push_accepted", {31'd0, guard < 2000}, 1);
      @(posedge clock);
      #1 bus.char_valid = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int   guard   = 0;
      logic reached = 1'b0;
      while (!reached && guard < 1000) begin
         @(negedge clock);
         reached = !seq_busy && fifo_count == 0 && !drawer_busy && !bus.start_writing_character;
         guard++;
      end
      check_output({name, "_idle"}, {31'd0, reached}, 1);
   endtask

   task automatic do_reset();
      int guard = 0;
      while (drawer_busy && guard < 100) begin
         @(negedge clock);
         guard++;
      end
      @(negedge clock);
      reset          = 1'b1;
      bus.char_valid = 1'b0;
      bus.char_in    = 8'h00;
      repeat (2) @(negedge clock);
      reset = 1'b0;
      drawn_char.delete();
      drawn_addr.delete();
   endtask

   task automatic check_cursor(input string name, input logic [4:0] col, input logic [3:0] row);
      check_output({name, "_col"}, cursor_col, col);
      check_output({name, "_row"}, cursor_row, row);
   endtask

   initial begin
      reset          = 1'b1;
      hold_busy      = 1'b0;
      bus.char_valid = 1'b0;
      bus.char_in    = 8'h00;

      vectors[0]  = '{8'h48, 1'b1, 8'h48, 19'd0,     5'd1, 4'd0};
      vectors[1]  = '{8'h69, 1'b1, 8'h69, 19'd20,    5'd2, 4'd0};
      vectors[2]  = '{8'h0A, 1'b0, 8'h00, 19'd0,     5'd0, 4'd1};
      vectors[3]  = '{8'h43, 1'b1, 8'h43, 19'd19200, 5'd1, 4'd1};
      vectors[4]  = '{8'h0A, 1'b0, 8'h00, 19'd0,     5'd0, 4'd2};
      vectors[5]  = '{8'h31, 1'b1, 8'h31, 19'd38400, 5'd1, 4'd2};
      vectors[6]  = '{8'h32, 1'b1, 8'h32, 19'd38420, 5'd2, 4'd2};
      vectors[7]  = '{8'h33, 1'b1, 8'h33, 19'd38440, 5'd3, 4'd2};
      vectors[8]  = '{8'h34, 1'b1, 8'h34, 19'd38460, 5'd4, 4'd2};
      vectors[9]  = '{8'h35, 1'b1, 8'h35, 19'd38480, 5'd5, 4'd2};
      vectors[10] = '{8'h0A, 1'b0, 8'h00, 19'd0,     5'd0, 4'd3};
      vectors[11] = '{8'h71, 1'b1, 8'h71, 19'd57600, 5'd1, 4'd3};
`ifdef TYPER_BACKSPACE_EN
      vectors[12] = '{8'h08, 1'b1, 8'h20, 19'd57600, 5'd0, 4'd3};
`else
      vectors[12] = '{8'h08, 1'b1, 8'h08, 19'd57620, 5'd2, 4'd3};
`endif

      repeat (2) @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      $display("[TB] reset state");
      check_output("rst_start", bus.start_writing_character, 0);
      check_output("rst_char", bus.character_output, 0);
      check_output("rst_addr", bus.top_left_corner_address, 0);
      check_output("rst_ready", bus.char_ready, 1);
      check_output("rst_count", fifo_count, 0);
      check_output("rst_busy", seq_busy, 0);
      check_cursor("rst", 5'd0, 4'd0);

      // First-character latency: push at edge N, request visible after edge N+1.
      $display("[TB] first character latency");
      @(negedge clock);
      bus.char_in    = 8'h41;
      bus.char_valid = 1'b1;
      @(posedge clock);
      #1 bus.char_valid = 1'b0;
      check_output("lat_count_n", fifo_count, 1);
      check_output("lat_start_n", bus.start_writing_character, 0);
      @(posedge clock);
      #1;
      check_output("lat_start_n1", bus.start_writing_character, 1);
      check_output("lat_char", bus.character_output, 8'h41);
      check_output("lat_addr", bus.top_left_corner_address, 0);
      check_output("lat_count_n1", fifo_count, 0);
      wait_idle("lat");
      check_cursor("lat", 5'd1, 4'd0);

      $display("[TB] table vectors");
      do_reset();
      for (int i = 0; i < 13; i++) begin
         apply_stimulus(vectors[i].code);
         wait_idle($sformatf("vec%0d", i));
         check_cursor($sformatf("vec%0d", i), vectors[i].exp_col, vectors[i].exp_row);
         if (vectors[i].drawn) begin
            check_output($sformatf("vec%0d_drawn", i), drawn_char.size(), 1);
            if (drawn_char.size() > 0) begin
               check_output($sformatf("vec%0d_char", i), drawn_char.pop_front(), vectors[i].exp_char);
               check_output($sformatf("vec%0d_addr", i), drawn_addr.pop_front(), vectors[i].exp_addr);
            end
         end else begin
            check_output($sformatf("vec%0d_nodraw", i), drawn_char.size(), 0);
         end
      end

      $display("[TB] line wrap");
      do_reset();
      for (int i = 0; i < 33; i++) apply_stimulus(8'(8'h41 + i));
      wait_idle("wrap");
      check_output("wrap_drawn", drawn_char.size(), 33);
      if (drawn_char.size() == 33) begin
         check_output("wrap_addr31", drawn_addr[31], 620);
         check_output("wrap_addr32", drawn_addr[32], 19200);
         check_output("wrap_char32", drawn_char[32], 8'h61);
      end
      check_cursor("wrap", 5'd1, 4'd1);

      $display("[TB] screen wrap");
      do_reset();
      for (int i = 0; i < 15; i++) apply_stimulus(ASCII_LF);
      for (int i = 0; i < 31; i++) apply_stimulus(8'h2E);
      wait_idle("scr_fill");
      check_cursor("scr_fill", 5'd31, 4'd15);
      drawn_char.delete();
      drawn_addr.delete();
      apply_stimulus(8'h58);
      wait_idle("scr_last");
      check_output("scr_last_addr", drawn_addr.size() > 0 ? drawn_addr.pop_front() : 19'h7FFFF, 288620);
      check_cursor("scr_last", 5'd0, 4'd0);
      apply_stimulus(8'h59);
      wait_idle("scr_next");
      check_output("scr_next_addr", drawn_addr.size() > 0 ? drawn_addr.pop_front() : 19'h7FFFF, 0);
      check_cursor("scr_next", 5'd1, 4'd0);

      $display("[TB] backpressure");
      do_reset();
      hold_busy = 1'b1;
      for (int i = 0; i < 8; i++) apply_stimulus(8'(8'h61 + i));
      @(negedge clock);
      check_output("bp_ready", bus.char_ready, 0);
      check_output("bp_count", fifo_count, 8);
      check_output("bp_busy", seq_busy, 0);
      bus.char_in    = 8'h69;
      bus.char_valid = 1'b1;
      repeat (3) @(negedge clock);
      check_output("bp_count_held", fifo_count, 8);
      check_output("bp_no_start", bus.start_writing_character, 0);
      hold_busy = 1'b0;
      apply_stimulus(8'h69);
      apply_stimulus(8'h6A);
      wait_idle("bp");
      check_output("bp_drawn", drawn_char.size(), 10);
      if (drawn_char.size() == 10) begin
         for (int i = 0; i < 10; i++) begin
            check_output($sformatf("bp_char%0d", i), drawn_char[i], 8'(8'h61 + i));
            check_output($sformatf("bp_addr%0d", i), drawn_addr[i], 20 * i);
         end
      end
      check_cursor("bp", 5'd10, 4'd0);

      $display("[TB] reset during WAIT");
      do_reset();
      apply_stimulus(8'h50);
      wait_idle("mid_pre");
      check_cursor("mid_pre", 5'd1, 4'd0);
      drawn_char.delete();
      drawn_addr.delete();
      apply_stimulus(8'h52);
      apply_stimulus(8'h53);
      apply_stimulus(8'h54);
      begin
         int   guard = 0;
         logic found = 1'b0;
         while (!found && guard < 200) begin
            @(negedge clock);
            found = seq_busy && !bus.start_writing_character && drawer_busy;
            guard++;
         end
         check_output("mid_wait_seen", {31'd0, found}, 1);
      end
      reset = 1'b1;
      #1;
      check_output("mid_start", bus.start_writing_character, 0);
      check_output("mid_busy", seq_busy, 0);
      check_output("mid_count", fifo_count, 0);
      check_output("mid_char", bus.character_output, 0);
      check_output("mid_addr", bus.top_left_corner_address, 0);
      check_cursor("mid", 5'd0, 4'd0);
      @(negedge clock);
      reset = 1'b0;
      wait_idle("mid_post");
      check_output("mid_drawn", drawn_char.size(), 1);
      check_cursor("mid_post", 5'd0, 4'd0);

`ifdef TYPER_BACKSPACE_EN
      $display("[TB] backspace");
      do_reset();
      apply_stimulus(ASCII_LF);
      apply_stimulus(ASCII_BS);
      wait_idle("bs_row");
      check_output("bs_row_drawn", drawn_char.size(), 1);
      if (drawn_char.size() > 0) begin
         check_output("bs_row_char", drawn_char.pop_front(), 8'h20);
         check_output("bs_row_addr", drawn_addr.pop_front(), 620);
      end
      check_cursor("bs_row", 5'd31, 4'd0);
      do_reset();
      apply_stimulus(ASCII_BS);
      wait_idle("bs_home");
      check_output("bs_home_drawn", drawn_char.size(), 1);
      if (drawn_char.size() > 0) begin
         check_output("bs_home_char", drawn_char.pop_front(), 8'h20);
         check_output("bs_home_addr", drawn_addr.pop_front(), 0);
      end
      check_cursor("bs_home", 5'd0, 4'd0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
